// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions used by the arbiter, register status table, reservation
// stations and register file.
//   CdbNumReq / CdbTagW / CdbDataW / CdbAddrW : default widths of the bus.
//   cdb_beat_t : field ordering of one CDB beat, MSB first.
package cdb_arbiter_pkg;

  localparam int unsigned CdbNumReq = 4;
  localparam int unsigned CdbTagW   = 6;
  localparam int unsigned CdbDataW  = 32;
  localparam int unsigned CdbAddrW  = 5;

  typedef struct packed {
    logic                valid;
    logic [CdbTagW-1:0]  tag;
    logic [CdbDataW-1:0] data;
    logic [CdbAddrW-1:0] rdaddr;
    logic                rdwen;
  } cdb_beat_t;

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req : request vector
//   ptr : index holding highest priority this cycle
//   gnt : one-hot grant, or zero when req is zero
// Rotates req so ptr lands at bit 0, picks the lowest set bit, and rotates the
// grant back to the original bit positions.
module rr_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned N = CdbNumReq,
  localparam int unsigned PtrW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [PtrW-1:0] ptr,
  output logic [N-1:0]    gnt
);

  logic [N-1:0] w_rot;
  logic [N-1:0] w_rot_gnt;

  // Doubling the vector makes the shift a rotate without modulo arithmetic.
  assign w_rot     = N'({req, req} >> ptr);
  assign w_rot_gnt = w_rot & (~w_rot + N'(1));
  assign gnt       = N'(({w_rot_gnt, w_rot_gnt} << ptr) >> N);

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: grants at most one completing unit per cycle and
// registers its result onto the CDB.
//   clk, reset      : clock, synchronous active-high reset
//   flush           : squash; blocks grants and the next CDB beat
//   req_*           : per-unit request, urgent flag and packed payload
//   req_grant       : combinational one-hot grant
//   cdb_*           : registered winning beat, valid for one cycle per grant
// Urgent requests (fixed-latency units) win by lowest index; otherwise
// round-robin from rr_ptr. Any grant moves rr_ptr just past the winner.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = CdbNumReq,
  parameter int unsigned TAG_W   = CdbTagW,
  parameter int unsigned DATA_W  = CdbDataW,
  parameter int unsigned ADDR_W  = CdbAddrW
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_urgent,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*ADDR_W-1:0] req_rdaddr,
  input  logic [NUM_REQ-1:0]        req_rdwen,
  output logic [NUM_REQ-1:0]        req_grant,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [ADDR_W-1:0]         cdb_rdaddr,
  output logic                      cdb_rdwen
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);

  logic [PtrW-1:0]    r_rr_ptr;
  logic               r_cdb_valid;
  logic [TAG_W-1:0]   r_cdb_tag;
  logic [DATA_W-1:0]  r_cdb_data;
  logic [ADDR_W-1:0]  r_cdb_rdaddr;
  logic               r_cdb_rdwen;

  logic [NUM_REQ-1:0] w_urg;
  logic [NUM_REQ-1:0] w_urg_gnt;
  logic [NUM_REQ-1:0] w_rr_gnt;
  logic [NUM_REQ-1:0] w_gnt;
  logic               w_any_gnt;
  logic [PtrW-1:0]    w_win_idx;
  logic [PtrW-1:0]    w_rr_ptr_nxt;
  logic [TAG_W-1:0]   w_tag;
  logic [DATA_W-1:0]  w_data;
  logic [ADDR_W-1:0]  w_rdaddr;
  logic               w_rdwen;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .req (req_valid),
    .ptr (r_rr_ptr),
    .gnt (w_rr_gnt)
  );

  // Lowest-index urgent requester; urgent units cannot stall so they bypass RR.
  assign w_urg     = req_valid & req_urgent;
  assign w_urg_gnt = w_urg & (~w_urg + NUM_REQ'(1));

  always_comb begin
    w_gnt = '0;
    if (!reset && !flush) begin
      w_gnt = (|w_urg) ? w_urg_gnt : w_rr_gnt;
    end
  end

  assign w_any_gnt = |w_gnt;

  // Grant is one-hot, so at most one iteration matches.
  always_comb begin
    w_win_idx = '0;
    w_tag     = '0;
    w_data    = '0;
    w_rdaddr  = '0;
    w_rdwen   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_win_idx = PtrW'(i);
        w_tag     = req_tag[i*TAG_W +: TAG_W];
        w_data    = req_data[i*DATA_W +: DATA_W];
        w_rdaddr  = req_rdaddr[i*ADDR_W +: ADDR_W];
        w_rdwen   = req_rdwen[i];
      end
    end
  end

  assign w_rr_ptr_nxt = (w_win_idx == PtrW'(NUM_REQ - 1)) ? '0 : w_win_idx + PtrW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr     <= '0;
      r_cdb_valid  <= 1'b0;
      r_cdb_tag    <= '0;
      r_cdb_data   <= '0;
      r_cdb_rdaddr <= '0;
      r_cdb_rdwen  <= 1'b0;
    end else begin
      // Flush already forced w_gnt to zero, so the beat drops and rr_ptr holds.
      r_cdb_valid <= w_any_gnt;
      if (w_any_gnt) begin
        r_rr_ptr     <= w_rr_ptr_nxt;
        r_cdb_tag    <= w_tag;
        r_cdb_data   <= w_data;
        r_cdb_rdaddr <= w_rdaddr;
        r_cdb_rdwen  <= w_rdwen;
      end
    end
  end

  assign req_grant  = w_gnt;
  assign cdb_valid  = r_cdb_valid;
  assign cdb_tag    = r_cdb_tag;
  assign cdb_data   = r_cdb_data;
  assign cdb_rdaddr = r_cdb_rdaddr;
  assign cdb_rdwen  = r_cdb_rdwen;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed steps from the test plan followed by a
// randomized phase, all checked against a behavioural model of the arbiter.
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int TW = 6;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic            flush;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_urgent;
  logic [N*TW-1:0] req_tag;
  logic [N*DW-1:0] req_data;
  logic [N*AW-1:0] req_rdaddr;
  logic [N-1:0]    req_rdwen;
  logic [N-1:0]    req_grant;
  logic            cdb_valid;
  logic [TW-1:0]   cdb_tag;
  logic [DW-1:0]   cdb_data;
  logic [AW-1:0]   cdb_rdaddr;
  logic            cdb_rdwen;

  cdb_arbiter #(
    .NUM_REQ (N),
    .TAG_W   (TW),
    .DATA_W  (DW),
    .ADDR_W  (AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_urgent (req_urgent),
    .req_tag    (req_tag),
    .req_data   (req_data),
    .req_rdaddr (req_rdaddr),
    .req_rdwen  (req_rdwen),
    .req_grant  (req_grant),
    .cdb_valid  (cdb_valid),
    .cdb_tag    (cdb_tag),
    .cdb_data   (cdb_data),
    .cdb_rdaddr (cdb_rdaddr),
    .cdb_rdwen  (cdb_rdwen)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  int            m_ptr;
  logic          m_valid;
  logic [TW-1:0] m_tag;
  logic [DW-1:0] m_data;
  logic [AW-1:0] m_rdaddr;
  logic          m_rdwen;
  int            last_g;
  logic [N-1:0]  prev_urg;
  logic [N-1:0]  obs_gnt;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Winner chosen from the rules: lowest urgent index, else first valid from ptr.
  function automatic int model_pick();
    if (reset || flush) return -1;
    for (int i = 0; i < N; i++) if (req_valid[i] && req_urgent[i]) return i;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (req_valid[j]) return j;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic v, input logic u, input logic [TW-1:0] t,
                         input logic [DW-1:0] d, input logic [AW-1:0] a, input logic w);
    req_valid[i]            = v;
    req_urgent[i]           = u;
    req_tag[i*TW +: TW]     = t;
    req_data[i*DW +: DW]    = d;
    req_rdaddr[i*AW +: AW]  = a;
    req_rdwen[i]            = w;
  endtask

  task automatic clear_reqs();
    req_valid  = '0;
    req_urgent = '0;
    req_tag    = '0;
    req_data   = '0;
    req_rdaddr = '0;
    req_rdwen  = '0;
  endtask

  // One clock: inputs were applied at the preceding negedge.
  task automatic cycle();
    int g;
    logic [N-1:0] eg;
    #1;
    g  = model_pick();
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    obs_gnt = req_grant;
    chk("grant", 64'(req_grant), 64'(eg));
    // Fixed-latency units must not be urgent in two consecutive cycles.
    chk("urgent_consecutive", 64'(req_valid & req_urgent & prev_urg), 64'd0);
    @(posedge clk);
    if (reset) begin
      m_ptr = 0; m_valid = 1'b0; m_tag = '0; m_data = '0; m_rdaddr = '0; m_rdwen = 1'b0;
    end else if (g >= 0) begin
      m_valid  = 1'b1;
      m_tag    = req_tag[g*TW +: TW];
      m_data   = req_data[g*DW +: DW];
      m_rdaddr = req_rdaddr[g*AW +: AW];
      m_rdwen  = req_rdwen[g];
      m_ptr    = (g + 1) % N;
    end else begin
      m_valid = 1'b0;
    end
    prev_urg = req_valid & req_urgent;
    last_g   = g;
    #1;
    chk("cdb_valid", 64'(cdb_valid), 64'(m_valid));
    chk("cdb_tag", 64'(cdb_tag), 64'(m_tag));
    chk("cdb_data", 64'(cdb_data), 64'(m_data));
    chk("cdb_rdaddr", 64'(cdb_rdaddr), 64'(m_rdaddr));
    chk("cdb_rdwen", 64'(cdb_rdwen), 64'(m_rdwen));
    chk("rr_ptr", 64'(dut.r_rr_ptr), 64'(m_ptr));
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; clear_reqs();
    m_ptr = 0; m_valid = 1'b0; m_tag = '0; m_data = '0; m_rdaddr = '0; m_rdwen = 1'b0;
    last_g = -1; prev_urg = '0; obs_gnt = '0;
    @(negedge clk);

    // Reset, then idle
    cycle();
    cycle();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) cycle();
    chk("idle_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("idle_ptr", 64'(dut.r_rr_ptr), 64'd0);

    // Single request from unit 2
    set_req(2, 1'b1, 1'b0, 6'h15, 32'hDEADBEEF, 5'd7, 1'b1);
    cycle();
    chk("single_grant", 64'(obs_gnt), 64'b0100);
    chk("single_cdb_valid", 64'(cdb_valid), 64'd1);
    chk("single_cdb_tag", 64'(cdb_tag), 64'h15);
    chk("single_cdb_data", 64'(cdb_data), 64'hDEADBEEF);
    chk("single_cdb_rdaddr", 64'(cdb_rdaddr), 64'd7);
    req_valid[2] = 1'b0;
    cycle();
    chk("single_after", 64'(cdb_valid), 64'd0);
    chk("single_hold_tag", 64'(cdb_tag), 64'h15);

    // Round-robin fairness from rr_ptr=0
    reset = 1'b1; cycle(); reset = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, TW'(8'h10 + i), DW'(i), AW'(i), 1'b1);
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("rr_order", 64'(obs_gnt), 64'(1) << (k % N));
      chk("rr_cdb_tag", 64'(cdb_tag), 64'h10 + 64'(k % N));
    end

    // Urgent override
    reset = 1'b1; clear_reqs(); cycle(); reset = 1'b0;
    set_req(0, 1'b1, 1'b0, 6'h01, 32'h1111, 5'd1, 1'b1);
    set_req(3, 1'b1, 1'b1, 6'h03, 32'h3333, 5'd3, 1'b0);
    cycle();
    chk("urgent_grant", 64'(obs_gnt), 64'b1000);
    chk("urgent_ptr", 64'(dut.r_rr_ptr), 64'd0);
    set_req(3, 1'b0, 1'b0, 6'h03, 32'h3333, 5'd3, 1'b0);
    cycle();
    chk("urgent_next", 64'(obs_gnt), 64'b0001);
    chk("urgent_cdb_tag", 64'(cdb_tag), 64'h01);

    // Flush blocks a grant; unit 1 keeps requesting and wins next cycle
    reset = 1'b1; clear_reqs(); cycle(); reset = 1'b0;
    set_req(1, 1'b1, 1'b0, 6'h21, 32'hCAFE0001, 5'd9, 1'b1);
    flush = 1'b1;
    cycle();
    chk("flush_grant", 64'(obs_gnt), 64'd0);
    chk("flush_cdb_valid", 64'(cdb_valid), 64'd0);
    flush = 1'b0;
    cycle();
    chk("flush_regrant", 64'(obs_gnt), 64'b0010);
    chk("flush_regrant_tag", 64'(cdb_tag), 64'h21);
    // A beat already on the bus survives a flush; only the next beat drops
    set_req(1, 1'b0, 1'b0, 6'h21, 32'hCAFE0001, 5'd9, 1'b1);
    set_req(0, 1'b1, 1'b0, 6'h2A, 32'hCAFE0002, 5'd4, 1'b0);
    cycle();
    chk("preflush_beat", 64'(cdb_valid), 64'd1);
    set_req(0, 1'b0, 1'b0, 6'h2A, 32'hCAFE0002, 5'd4, 1'b0);
    set_req(2, 1'b1, 1'b0, 6'h2B, 32'hCAFE0003, 5'd5, 1'b1);
    flush = 1'b1;
    cycle();
    chk("postflush_beat", 64'(cdb_valid), 64'd0);
    flush = 1'b0;

    // Reset mid-stream, together with flush
    clear_reqs();
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, 1'b0, TW'(8'h30 + i), DW'(i), AW'(i), 1'b1);
    cycle();
    cycle();
    reset = 1'b1; flush = 1'b1;
    cycle();
    chk("midreset_grant", 64'(obs_gnt), 64'd0);
    chk("midreset_valid", 64'(cdb_valid), 64'd0);
    chk("midreset_ptr", 64'(dut.r_rr_ptr), 64'd0);
    reset = 1'b0; flush = 1'b0;
    cycle();
    chk("midreset_first", 64'(obs_gnt), 64'b0001);

    // Randomized traffic
    clear_reqs();
    for (int c = 0; c < 600; c++) begin
      if (last_g >= 0) req_valid[last_g] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0)
          set_req(i, 1'b1, 1'b0, TW'($urandom), $urandom, AW'($urandom), 1'($urandom));
      end
      for (int i = 0; i < N; i++)
        req_urgent[i] = req_valid[i] && !prev_urg[i] && ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 60) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single Common Data Bus (CDB) among NUM_REQ completing execution units, e.g. integer, multiply, divide and load/store.
- Grants at most one completion per cycle.
- Registers the winner onto the CDB, which feeds the register status table clear port (cdb_tag/cdb_valid), the reservation stations and the register file.
- Arbitration is round-robin, with an urgent override for fixed-latency units that cannot hold results.

Parameters:
- NUM_REQ, 4, number of requesting units (2..8).
- TAG_W, 6, ROB/RST tag width.
- DATA_W, 32, result data width.
- ADDR_W, 5, architectural destination register address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous squash; drops the registered CDB beat and blocks grants this cycle.
- req_valid  in  NUM_REQ  per-unit completion request; held until granted.
- req_urgent  in  NUM_REQ  per-unit urgent flag; only meaningful when req_valid is set.
- req_tag  in  NUM_REQ*TAG_W  per-unit tag, unit i at bits [i*TAG_W +: TAG_W].
- req_data  in  NUM_REQ*DATA_W  per-unit result.
- req_rdaddr  in  NUM_REQ*ADDR_W  per-unit destination register.
- req_rdwen  in  NUM_REQ  per-unit "writes a register" flag (0 for stores and branches).
- req_grant  out  NUM_REQ  one-hot or zero; combinational from the current inputs and pointer.
- cdb_valid  out  1  registered CDB beat valid.
- cdb_tag  out  TAG_W  registered winning tag.
- cdb_data  out  DATA_W  registered winning data.
- cdb_rdaddr  out  ADDR_W  registered winning destination.
- cdb_rdwen  out  1  registered winning write enable.

Behaviour:
- Reset: reset=1 at a rising edge sets cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_rdaddr=0, cdb_rdwen=0 and rr_ptr=0. While reset is high, req_grant=0.
- Grant selection (combinational, each cycle):
  - If any req_valid&req_urgent bit is set, the winner is the lowest index among those bits.
  - Otherwise, the winner is the first req_valid bit found scanning upward from rr_ptr with wrap-around (rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ...).
  - No valid request gives req_grant=0.
- Handshake:
  - A unit drops or replaces its request in the cycle after it sees req_grant[i]=1.
  - An ungranted request keeps its payload stable.
  - The arbiter never grants an invalid requester.
- Latency: the grant in cycle N produces the CDB beat in cycle N+1. cdb_valid=1 for exactly one cycle per grant; back-to-back grants give one beat per cycle.
- Payload when no grant: cdb_valid=0 and cdb_tag/cdb_data/cdb_rdaddr/cdb_rdwen hold their previous values.
- Pointer: on any grant (urgent or not) to index w, rr_ptr <= (w+1) mod NUM_REQ. Without a grant, rr_ptr holds.
- Flush:
  - flush=1 forces req_grant=0 and cdb_valid<=0 at the edge, and rr_ptr holds.
  - A beat already on the CDB in the flush cycle is still presented that cycle; only the next beat is suppressed.
- Simultaneous reset and flush: reset dominates.
- Urgent starvation: with two urgent units both continuously urgent, the lower index wins every cycle. Fixed-latency units must not assert urgent in consecutive cycles; this is a system-level invariant, checked by assertion in the bench.

Decomposition:
- Shared package: TAG_W, DATA_W and ADDR_W defaults, and the CDB beat field ordering, reused by the RST, reservation stations and regfile.
- One sub-module, rr_arbiter, with the following contract:
  - parameter N; inputs req[N], ptr[log2 N]; output gnt[N], one-hot or zero.
  - Pure combinational rotate / priority-encode / rotate-back.
- The top-level block holds rr_ptr, the urgent override, the payload mux and the output register.

Test Plan:
- Reset, then idle: all req_valid=0 for 10 cycles -> cdb_valid=0 throughout, req_grant=0, rr_ptr=0.
- Single request: unit 2 with req_valid=1, tag=0x15, data=0xDEADBEEF, rdaddr=7, rdwen=1 in cycle N -> req_grant=4'b0100 in N; next cycle cdb_valid=1, cdb_tag=0x15, cdb_data=0xDEADBEEF, cdb_rdaddr=7, cdb_rdwen=1; the cycle after, cdb_valid=0.
- Round-robin fairness: all 4 units continuously valid from rr_ptr=0 -> grants 0,1,2,3,0,1,... one per cycle, and CDB tags follow the same order one cycle later.
- Urgent override: rr_ptr=0, units 0 and 3 valid, unit 3 urgent -> unit 3 granted; rr_ptr becomes 0 and unit 0 is granted the next cycle.
- Flush: grant to unit 1 in cycle N with flush=1 in N -> req_grant=0 and cdb_valid=0 in N+1; unit 1 keeps requesting and is granted in N+1.
- Reset mid-stream: reset asserted while 3 units request -> the next cycle has cdb_valid=0 and rr_ptr=0; after deassertion, unit 0 is granted first.
